instr_stream_encoder: RTL
=========================

Name: instr_stream_encoder

Overview:
- Inverse of the opcode decoder: accepts instruction-field tuples (R-type, lw, sw, beq) over a valid/ready handshake.
- Encodes each tuple into a 32-bit MIPS word and buffers it in a small FIFO.
- Writes the buffered words sequentially into instruction memory through a handshaked write port.
- Used as the program loader/test-program generator in front of instruction memory.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- ADDR_W, 32, byte-address width of the memory write port.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE)
- base_addr  in  ADDR_W  first byte address; latched on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept a tuple
- in_kind  in  2  00 R-type, 01 lw, 10 sw, 11 beq
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field (R-type only)
- in_shamt  in  5  shamt field (R-type only)
- in_funct  in  6  funct field (R-type only)
- in_imm  in  16  immediate/offset (lw/sw/beq)
- in_last  in  1  marks the final tuple of the session
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_W  byte address of the current write
- mem_wdata  out  32  encoded instruction word
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the session completes
- word_count  out  ADDR_W  words written this session

Behaviour:
- Encoding, combinational on accept; stored words are never re-encoded:
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=0, mem_we=0. start -> RUN; latch base_addr into the address register; clear word_count; FIFO already empty.
  - RUN: push tuples; drain to memory. When a word whose stored last flag is 1 pops -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Accept rule:
  - push = in_valid && in_ready.
  - in_ready = (state==RUN) && !full && !last_seen.
  - last_seen sets on pushing a tuple with in_last=1 and clears on start. No tuples are accepted after the last one.
- FIFO:
  - Registered storage of {last, word[31:0]}; head/tail pointers with an occupancy count.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: in_ready=0; there is no same-cycle pass-through when full.
  - Pointers wrap modulo DEPTH.
- Write side:
  - mem_we = (state==RUN) && !empty.
  - mem_wdata = head word; mem_addr = address register.
  - pop = mem_we && mem_ready.
  - On pop: address += 4, wrapping modulo 2^ADDR_W; word_count += 1.
  - While mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Latency: a tuple accepted at edge N is visible on mem_wdata/mem_we in the following cycle, one cycle minimum.
- Reset, asynchronous, any state:
  - state=IDLE; FIFO flushed (pointers and count 0); last_seen=0.
  - Address register 0, word_count 0.
  - in_ready=0, mem_we=0, busy=0, done=0.
  - A session interrupted by reset is abandoned with no done pulse.
- busy = (state==RUN).

Test Plan:
- Reset, base_addr=0x100, start. Push R{rs=8,rt=9,rd=10,shamt=0,funct=0x20} with last=1, mem_ready=1 -> one write mem_addr=0x100, mem_wdata=0x01095020; then done pulse; word_count=1; return to IDLE.
- Push lw{rs=17,rt=8,imm=4}, sw{rs=17,rt=10,imm=8}, beq{rs=8,rt=9,imm=0xFFFF, last} back-to-back -> writes 0x8E280004 @0x100, 0xAE2A0008 @0x104, 0x1109FFFF @0x108; word_count=3.
- Hold mem_ready=0 and push DEPTH tuples -> in_ready=0 after the 4th accept. mem_we/mem_addr/mem_wdata stable. Release mem_ready -> in-order drain, in_ready reasserts one cycle after the first pop.
- base_addr=0xFFFFFFFC, two words -> addresses 0xFFFFFFFC then 0x00000000.
- Assert rst mid-session with 2 words buffered -> all outputs at reset values immediately, no done. New start at base 0x200 with 1 word -> write @0x200, word_count=1.
- start pulsed during RUN and in_valid held after the last tuple -> start ignored, no extra accepts, exactly one done pulse.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// Generic FIFO: registered storage, head/tail pointers, occupancy count.
// Latency: a write is visible at the head one cycle after the accepting edge.
// Backpressure: writes are dropped while full (no pass-through); reads ignored while empty.
module isenc_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          wr, rd;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign wr     = wr_vld && !full;
  assign rd     = rd_rdy && !empty;
  assign rd_dat = mem[head];

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= wr_dat;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + AW'(1);
      if (rd) head <= head + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Encodes R/lw/sw/beq field tuples into MIPS words and streams them into instruction memory.
// Latency: a tuple accepted at edge N drives mem_we/mem_wdata from the following cycle.
// Backpressure: in_ready drops when the FIFO is full or the last tuple was taken; mem_ready=0 holds the write.
// Ports: clk/rst; start+base_addr open a session; in_* tuple handshake with in_last;
//        mem_we/mem_ready/mem_addr/mem_wdata write port; busy, done pulse, word_count status.
module instr_stream_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              last_seen;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic              push, pop, full, empty;
  logic [31:0]       enc_word;
  logic [32:0]       head_dat;

  always_comb begin
    enc_word = '0;
    case (in_kind)
      2'b00:   enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      2'b01:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
      2'b10:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
      default: enc_word = {6'b000100, in_rs, in_rt, in_imm};
    endcase
  end

  assign in_ready   = (state == RUN) && !full && !last_seen;
  assign push       = in_valid && in_ready;
  assign mem_we     = (state == RUN) && !empty;
  assign pop        = mem_we && mem_ready;
  assign mem_addr   = addr_q;
  assign mem_wdata  = head_dat[31:0];
  assign word_count = wcnt_q;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  // Each entry carries its own last flag so the session ends exactly when the
  // final word has been written, not when it was accepted.
  isenc_fifo #(.W(33), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat ({in_last, enc_word}),
    .rd_rdy (pop),
    .rd_dat (head_dat),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_seen <= 1'b0;
      addr_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            addr_q    <= base_addr;
            wcnt_q    <= '0;
            last_seen <= 1'b0;
          end
        end
        RUN: begin
          if (push && in_last) last_seen <= 1'b1;
          if (pop) begin
            addr_q <= addr_q + ADDR_W'(4);
            wcnt_q <= wcnt_q + ADDR_W'(1);
            if (head_dat[32]) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
